bcd_7seg_scan_driver: RTL and testbench
=======================================

Name: bcd_7seg_scan_driver

Overview:
Multiplexed N-digit BCD-to-7-segment display driver with a refresh scan. It holds a shadow copy of the packed BCD word and decimal points, and time-slices one digit at a time onto a shared segment bus using a prescaled digit strobe. Options include leading-zero blanking, whole-display blanking and common-anode/common-cathode polarity. It sits between the datapath (counters, ALU results) and the board's multiplexed display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
PRESCALE, 1000, clk cycles per digit slot; must be >=1.
COMMON_ANODE, 1, 1 = segments, dp and anodes active-low; 0 = all active-high.
BLANK_LEADING, 1, 1 = suppress leading zeros; 0 = show all digits.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous reset, active-high.
bcd_in  in  4*NUM_DIGITS  packed BCD; bits [3:0] = digit 0 (least significant).
dp_in  in  NUM_DIGITS  decimal point per digit.
load  in  1  when high, captures bcd_in/dp_in into the shadow registers.
blank  in  1  when high, deselects all anodes.
seg  out  7  segments; seg[6]=a ... seg[0]=g, polarity per COMMON_ANODE.
dp  out  1  decimal point of the active digit.
an  out  NUM_DIGITS  digit enables; bit i = digit i.
digit_idx  out  max(1,clog2(NUM_DIGITS))  index of the digit currently driven.
frame_done  out  1  one-cycle pulse per completed scan frame.

Behaviour:
- Clocking and reset: single clock `clk`; reset `rst` is synchronous and active-high. All outputs are registered.
- Reset values: prescaler=0; scan index=0; shadow BCD and dp=0. Outputs: an all deselected, seg all off, dp off, digit_idx=0, frame_done=0. Polarity of these values follows COMMON_ANODE (CA: an, seg and dp all 1s). Asserting rst mid-frame returns all of this at the next edge.
- Prescaler: counts 0..PRESCALE-1 and wraps. "tick" = count==PRESCALE-1. With PRESCALE=1, tick fires every cycle.
- Output update on the tick edge:
  - an/seg/dp/digit_idx are latched for the digit at the current scan index.
  - The index then increments, wrapping NUM_DIGITS-1 -> 0.
  - First digit after reset release: digit 0 outputs are valid from cycle PRESCALE.
  - Outputs hold for exactly PRESCALE cycles per slot.
- frame_done: high for one cycle following the tick edge that latches digit NUM_DIGITS-1.
- Shadow registers:
  - On an edge with load=1, the shadow captures bcd_in/dp_in.
  - If load coincides with a tick, that tick's latched digit uses the old shadow. The new value appears from the next slot, so there is no mid-slot tearing.
- Decode (active-high internally, inverted at the output when COMMON_ANODE=1):
  - 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg.
  - Codes 10..15 = g only (dash, error indication).
- Leading-zero blanking (BLANK_LEADING=1):
  - Digit i>0 is blanked when it and every higher digit equal 0 in the shadow.
  - Digit 0 is never blanked.
  - A blanked digit's slot has its anode deselected, seg off and dp off. Scan timing is unchanged.
- blank input:
  - Sampled every edge; while high, an is forced all-deselected from the next edge.
  - Scan index, prescaler and frame_done keep running.
  - After blank falls, an resumes at the next tick, at whatever index the scan has reached.
- Invalid parameters (NUM_DIGITS=0, PRESCALE=0) are unsupported; a simulation assertion flags them.

Test Plan:
All scenarios use NUM_DIGITS=4, PRESCALE=4, COMMON_ANODE=1, BLANK_LEADING=1.
1. Reset: hold rst for 3 cycles, then release -> an=4'b1111, seg=7'b1111111, dp=1 until cycle 4; at cycle 4, an=4'b1110 and digit_idx=0.
2. Load 16'h1234 with dp_in=4'b0100 -> an cycles 1110, 1101, 1011, 0111, 4 cycles each. Digit 0 seg=7'b1001100 ("4"); digit 2 dp=0, others dp=1. frame_done pulses once every 16 cycles.
3. Load 16'h0070 -> digits 3 and 2 slots show an=4'b1111; digit 1 seg=7'b0001111 ("7"); digit 0 seg=7'b0000001 ("0"). Then load 16'h0000 -> only digit 0 is lit, seg=7'b0000001.
4. Load 16'h000A -> digit 0 seg=7'b1111110 (dash); digits 3..1 blanked.
5. Raise blank mid-slot of digit 1 -> an=4'b1111 at the next edge; frame_done still pulses on schedule. Drop blank -> an re-asserts at the next tick on the correct index.
6. Pulse load with 16'h9999 on the same edge as a tick -> that slot shows the old value and the next slot shows seg=7'b0000100 ("9"). Assert rst mid-frame -> all outputs return to reset values at the next edge.

Source files
------------

// File: rtl/bcd_7seg_scan_driver.sv
// Multiplexed N-digit BCD to 7-segment scan driver with leading-zero blanking,
// whole-display blanking and selectable common-anode/common-cathode polarity.
module bcd_7seg_scan_driver #(
   parameter int NUM_DIGITS    = 4,
   parameter int PRESCALE      = 1000,
   parameter bit COMMON_ANODE  = 1'b1,
   parameter bit BLANK_LEADING = 1'b1,
   localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   input  logic                    blank,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [IDX_W-1:0]        digit_idx,
   output logic                    frame_done
);

   localparam int                PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic              POL      = COMMON_ANODE;
   localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [PRE_W-1:0]          r_presc;
   logic [IDX_W-1:0]          r_idx;
   logic [4*NUM_DIGITS-1:0]   r_bcd;
   logic [NUM_DIGITS-1:0]     r_dp_sh;
   logic [NUM_DIGITS-1:0]     r_an;
   logic [6:0]                r_seg;
   logic                      r_dp;
   logic [IDX_W-1:0]          r_digit_idx;
   logic                      r_frame_done;

   logic                      w_tick;
   logic [3:0]                w_digit [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]     w_lz;
   logic [3:0]                w_cur;
   logic                      w_cur_dp;
   logic                      w_cur_blank;
   logic [NUM_DIGITS-1:0]     w_an_act;
   logic [6:0]                w_seg_act;

   assign w_tick = (r_presc == PRE_LAST);

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign w_digit[gi] = r_bcd[4*gi +: 4];
      end
   endgenerate

   // w_lz[i] is set when digit i and every digit above it are zero.
   always_comb begin
      logic v_zero;
      v_zero = 1'b1;
      w_lz   = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         v_zero  = v_zero & (w_digit[i] == 4'd0);
         w_lz[i] = v_zero;
      end
   end

   always_comb begin
      w_cur       = '0;
      w_cur_dp    = 1'b0;
      w_cur_blank = 1'b0;
      w_an_act    = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_cur       = w_digit[i];
            w_cur_dp    = r_dp_sh[i];
            w_cur_blank = BLANK_LEADING && (i > 0) && w_lz[i];
            w_an_act[i] = 1'b1;
         end
      end
   end

   // Active-high segment map, seg[6]=a .. seg[0]=g; non-decimal codes show a dash.
   always_comb begin
      case (w_cur)
         4'd0:    w_seg_act = 7'b1111110;
         4'd1:    w_seg_act = 7'b0110000;
         4'd2:    w_seg_act = 7'b1101101;
         4'd3:    w_seg_act = 7'b1111001;
         4'd4:    w_seg_act = 7'b0110011;
         4'd5:    w_seg_act = 7'b1011011;
         4'd6:    w_seg_act = 7'b1011111;
         4'd7:    w_seg_act = 7'b1110000;
         4'd8:    w_seg_act = 7'b1111111;
         4'd9:    w_seg_act = 7'b1111011;
         default: w_seg_act = 7'b0000001;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc      <= '0;
         r_idx        <= '0;
         r_bcd        <= '0;
         r_dp_sh      <= '0;
         r_an         <= {NUM_DIGITS{POL}};
         r_seg        <= {7{POL}};
         r_dp         <= POL;
         r_digit_idx  <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_presc      <= w_tick ? '0 : r_presc + 1'b1;
         r_frame_done <= w_tick && (r_idx == IDX_LAST);
         // Shadow updates land after this edge, so a coincident tick still shows the old value.
         if (load) begin
            r_bcd   <= bcd_in;
            r_dp_sh <= dp_in;
         end
         if (w_tick) begin
            r_idx       <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            r_seg       <= (w_cur_blank ? 7'd0 : w_seg_act) ^ {7{POL}};
            r_dp        <= (w_cur_dp & ~w_cur_blank) ^ POL;
            r_digit_idx <= r_idx;
         end
         if (blank) begin
            r_an <= {NUM_DIGITS{POL}};
         end else if (w_tick) begin
            r_an <= (w_cur_blank ? '0 : w_an_act) ^ {NUM_DIGITS{POL}};
         end
      end
   end

   always_ff @(posedge clk) begin
      assert (NUM_DIGITS >= 1 && NUM_DIGITS <= 8 && PRESCALE >= 1)
         else $error("bcd_7seg_scan_driver: unsupported NUM_DIGITS/PRESCALE");
   end

   assign seg        = r_seg;
   assign dp         = r_dp;
   assign an         = r_an;
   assign digit_idx  = r_digit_idx;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Bench for bcd_7seg_scan_driver: directed scenarios then random traffic, all
// outputs compared every cycle against a slot/time based reference model.
module tb_bcd_7seg_scan_driver;

   localparam int N  = 4;
   localparam int P  = 4;
   localparam bit CA = 1'b1;
   localparam bit BL = 1'b1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] bcd_in = '0;
   logic [3:0]  dp_in = '0;
   logic        load = 1'b0;
   logic        blank = 1'b0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic [1:0]  digit_idx;
   logic        frame_done;

   int tests = 0;
   int fails = 0;

   // Reference model state
   int          k;        // edges since reset release
   logic [15:0] sh;
   logic [3:0]  shdp;
   logic [3:0]  m_an;
   logic [6:0]  m_seg;
   logic        m_dp;
   int          m_idx;
   logic        m_fd;

   string pats [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg", "g", "g", "g", "g", "g", "g"};

   bcd_7seg_scan_driver #(
      .NUM_DIGITS(N), .PRESCALE(P), .COMMON_ANODE(CA), .BLANK_LEADING(BL)
   ) dut (
      .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load(load), .blank(blank),
      .seg(seg), .dp(dp), .an(an), .digit_idx(digit_idx), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [6:0] pattern(int n);
      logic [6:0] v;
      string      s;
      v = '0;
      s = pats[n];
      for (int i = 0; i < s.len(); i++) v[6 - (s[i] - 97)] = 1'b1;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
      end
   endtask

   task automatic model_edge(input logic l, input logic [15:0] b, input logic [3:0] d,
                             input logic bl, input logic r);
      bit          tick;
      int          dd;
      logic [15:0] upper;
      bit          bz;
      logic [3:0]  an_new;
      an_new = {4{CA}};
      if (r) begin
         k = 0; sh = '0; shdp = '0;
         m_an = {4{CA}}; m_seg = {7{CA}}; m_dp = CA; m_idx = 0; m_fd = 1'b0;
      end else begin
         tick = ((k + 1) % P) == 0;
         k++;
         m_fd = 1'b0;
         if (tick) begin
            dd    = ((k / P) - 1) % N;
            upper = sh >> (4 * dd);
            bz    = BL && (dd > 0) && (upper == 16'd0);
            m_idx = dd;
            m_fd  = (dd == N - 1);
            m_seg = (bz ? 7'd0 : pattern(int'(upper[3:0]))) ^ {7{CA}};
            m_dp  = (bz ? 1'b0 : shdp[dd]) ^ CA;
            an_new = (bz ? 4'd0 : 4'(1 << dd)) ^ {4{CA}};
         end
         if (bl)        m_an = {4{CA}};
         else if (tick) m_an = an_new;
         if (l) begin
            sh = b; shdp = d;
         end
      end
   endtask

   task automatic step(input logic l, input logic [15:0] b, input logic [3:0] d,
                       input logic bl, input logic r);
      load = l; bcd_in = b; dp_in = d; blank = bl; rst = r;
      if (l && !r) $display("[TB] load bcd=%h dp=%b blank=%b at k=%0d", b, d, bl, k);
      @(posedge clk);
      model_edge(l, b, d, bl, r);
      #1;
      chk("an", 32'(an), 32'(m_an));
      chk("seg", 32'(seg), 32'(m_seg));
      chk("dp", 32'(dp), 32'(m_dp));
      chk("digit_idx", 32'(digit_idx), 32'(m_idx));
      chk("frame_done", 32'(frame_done), 32'(m_fd));
   endtask

   // Advance until the edge that just latched digit d (bounded).
   task automatic run_to_digit(input int d);
      int n;
      n = 0;
      do begin
         step(1'b0, 16'($urandom), 4'($urandom), 1'b0, 1'b0);
         n++;
      end while (!((k > 0) && (k % P == 0) && (m_idx == d)) && n < 64);
      tests++;
      assert (n < 64) else begin
         fails++;
         $error("FAIL run_to_digit observed=%0d steps expected=<64", n);
      end
   endtask

   initial begin
      logic cur_blank;
      logic l;
      logic r;
      logic [15:0] b;
      k = 0; sh = '0; shdp = '0; m_an = '1; m_seg = '1; m_dp = 1'b1; m_idx = 0; m_fd = 1'b0;

      // 1: reset, then first slot after PRESCALE cycles
      repeat (3) step(1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
      repeat (P - 1) step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
      chk("rst_hold_an", 32'(an), 32'(4'b1111));
      chk("rst_hold_seg", 32'(seg), 32'(7'b1111111));
      step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
      chk("first_slot_an", 32'(an), 32'(4'b1110));
      chk("first_slot_idx", 32'(digit_idx), 32'(2'd0));

      // 2: 1234 with dp on digit 2
      step(1'b1, 16'h1234, 4'b0100, 1'b0, 1'b0);
      run_to_digit(0);
      chk("s2_seg0", 32'(seg), 32'(7'b1001100));
      run_to_digit(2);
      chk("s2_dp2", 32'(dp), 32'(1'b0));
      chk("s2_an2", 32'(an), 32'(4'b1011));
      repeat (2 * N * P) step(1'b0, 16'($urandom), 4'($urandom), 1'b0, 1'b0);

      // 3: leading zero blanking
      step(1'b1, 16'h0070, 4'b0000, 1'b0, 1'b0);
      run_to_digit(3);
      chk("s3_an3", 32'(an), 32'(4'b1111));
      run_to_digit(1);
      chk("s3_seg1", 32'(seg), 32'(7'b0001111));
      run_to_digit(0);
      chk("s3_seg0", 32'(seg), 32'(7'b0000001));
      step(1'b1, 16'h0000, 4'b1111, 1'b0, 1'b0);
      run_to_digit(1);
      chk("s3z_an1", 32'(an), 32'(4'b1111));
      chk("s3z_dp1", 32'(dp), 32'(1'b1));
      run_to_digit(0);
      chk("s3z_an0", 32'(an), 32'(4'b1110));

      // 4: invalid code shows dash
      step(1'b1, 16'h000A, 4'b0000, 1'b0, 1'b0);
      run_to_digit(0);
      chk("s4_seg0", 32'(seg), 32'(7'b1111110));
      run_to_digit(2);
      chk("s4_an2", 32'(an), 32'(4'b1111));

      // 5: blank mid-slot, frame_done keeps running
      step(1'b1, 16'h5678, 4'b0001, 1'b0, 1'b0);
      run_to_digit(1);
      step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
      step(1'b0, 16'h0, 4'h0, 1'b1, 1'b0);
      chk("s5_blank_an", 32'(an), 32'(4'b1111));
      repeat (N * P + 3) step(1'b0, 16'h0, 4'h0, 1'b1, 1'b0);
      repeat (N * P) step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);

      // 6: load coincident with a tick, then mid-frame reset
      while (((k + 1) % P) != 0) step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
      step(1'b1, 16'h9999, 4'b0000, 1'b0, 1'b0);
      repeat (P) step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
      chk("s6_next_seg", 32'(seg), 32'(7'b0000100));
      step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
      step(1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
      chk("s6_rst_an", 32'(an), 32'(4'b1111));
      chk("s6_rst_seg", 32'(seg), 32'(7'b1111111));
      chk("s6_rst_idx", 32'(digit_idx), 32'(2'd0));

      // Random traffic
      cur_blank = 1'b0;
      for (int i = 0; i < 600; i++) begin
         l = ($urandom_range(0, 7) == 0);
         b = 16'($urandom) >> (4 * $urandom_range(0, 4));
         if ($urandom_range(0, 19) == 0) cur_blank = ~cur_blank;
         r = ($urandom_range(0, 249) == 0);
         step(l, b, 4'($urandom), cur_blank, r);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
